// File: rtl/gf_iter_mult_ctrl.sv
// Digit-serial multiplier: carry-less GF(2)[x] product or unsigned integer
// product of two DATA_WIDTH operands. Consumes DIGIT bits of b per cycle,
// N = DATA_WIDTH/DIGIT compute cycles per operation, one operation in flight.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake (a, b, gf_option sampled at accept)
//   gf_option           - 1: carry-less product, 0: unsigned integer product
//   a, b                - multiplicand, multiplier
//   out_valid, out_ready- result handshake
//   out                 - registered 2*DATA_WIDTH result, held until next result
//   busy                - high while an operation is computing or awaiting handoff
module gf_iter_mult_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIGIT      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    gf_option,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out,
  output logic                    busy
);

  localparam int unsigned RW = 2 * DATA_WIDTH;
  localparam int unsigned N  = DATA_WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [RW-1:0]       a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic                mode;
  logic [RW-1:0]       acc;
  logic [CW-1:0]       cnt;

  logic [DIGIT-1:0]    d_c;
  logic [RW-1:0]       term_c;
  logic [RW-1:0]       partial_c;
  logic [RW-1:0]       acc_nxt_c;
  logic                accept_c;
  logic                last_c;

  assign accept_c = (state == IDLE) && in_valid;
  assign last_c   = (cnt == CW'(N - 1));

  // Partial product of the current digit, combined with acc by XOR or add.
  always_comb begin
    d_c       = b_sh[DIGIT-1:0];
    term_c    = '0;
    partial_c = '0;
    for (int unsigned j = 0; j < DIGIT; j++) begin
      term_c    = d_c[j] ? (a_sh << j) : '0;
      partial_c = mode ? (partial_c ^ term_c) : (partial_c + term_c);
    end
    acc_nxt_c = mode ? (acc ^ partial_c) : (acc + partial_c);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_c) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Datapath: operand shifters, accumulator, digit counter, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      mode <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      out  <= '0;
    end else if (accept_c) begin
      a_sh <= {{DATA_WIDTH{1'b0}}, a};
      b_sh <= b;
      mode <= gf_option;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc  <= acc_nxt_c;
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh >> DIGIT;
      cnt  <= cnt + CW'(1);
      if (last_c) out <= acc_nxt_c;
    end
  end

endmodule

// File: tb/tb_gf_iter_mult_ctrl.sv
// Directed, table-driven bench for gf_iter_mult_ctrl (DATA_WIDTH=32, DIGIT=4).
module tb_gf_iter_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        gf_option;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  int tests = 0;
  int fails = 0;

  gf_iter_mult_ctrl #(.DATA_WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .gf_option(gf_option), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the block expected idle; returns at the negedge of cycle 1.
  task automatic drive_accept(input string name, input logic m, input logic [31:0] x,
                              input logic [31:0] y);
    check({name, " in_ready at accept"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    gf_option = m;
    a         = x;
    b         = y;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    gf_option = 1'($urandom);
  endtask

  // Waits (bounded) for out_valid; lat is the cycle index relative to accept.
  task automatic wait_result(input string name, output logic [63:0] res, output int lat,
                             output bit held);
    int k = 1;
    held = 1'b1;
    while (!out_valid && k < 40) begin
      if (in_ready || !busy) held = 1'b0;
      @(negedge clk);
      k++;
    end
    lat = k;
    res = out;
    if (!out_valid) check({name, " out_valid timeout"}, 64'(out_valid), 64'd1);
  endtask

  // Completes the result transfer; in_ready must only rise the cycle after.
  task automatic handoff(input string name, input logic [63:0] exp);
    out_ready = 1'b1;
    check({name, " in_ready low at handoff"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " idle after handoff"}, {62'd0, out_valid, in_ready}, 64'd1);
    check({name, " out held after handoff"}, out, exp);
  endtask

  task automatic run_op(input string name, input logic m, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    logic [63:0] res;
    int          lat;
    bit          held;
    drive_accept(name, m, x, y);
    wait_result(name, res, lat, held);
    check({name, " result"}, res, exp);
    check({name, " latency"}, 64'(lat), 64'd9);
    check({name, " busy/in_ready during compute"}, 64'(held), 64'd1);
    handoff(name, exp);
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    bit          held;

    vecs[0] = '{"int_ffff_sq",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{"gf_3x3",       1'b1, 32'h3,        32'h3,        64'h5};
    vecs[2] = '{"int_3x3",      1'b0, 32'h3,        32'h3,        64'h9};
    vecs[3] = '{"gf_ffff_sq",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h5555555555555555};
    vecs[4] = '{"gf_7x7",       1'b1, 32'h7,        32'h7,        64'h15};
    vecs[5] = '{"int_7x7",      1'b0, 32'h7,        32'h7,        64'h31};
    vecs[6] = '{"gf_msb_sq",    1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[7] = '{"int_shift16",  1'b0, 32'h12345678, 32'h10,       64'h123456780};
    vecs[8] = '{"int_b_zero",   1'b0, 32'hDEADBEEF, 32'h0,        64'h0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    gf_option = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset out",       out,            64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Early out_ready has no effect while idle.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("early out_ready", {62'd0, in_ready, out_valid}, 64'd2);

    // Back-to-back table operations.
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Backpressure with an ignored request (a = 7) while DONE.
    drive_accept("bp", 1'b0, 32'd5, 32'd6);
    wait_result("bp", res, lat, held);
    check("bp result", res, 64'd30);
    in_valid = 1'b1; gf_option = 1'b0; a = 32'd7; b = 32'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp out stable", out, 64'd30);
      check("bp status", {61'd0, busy, in_ready, out_valid}, 64'd5);
    end
    in_valid = 1'b0;
    handoff("bp", 64'd30);
    run_op("bp_fresh", 1'b0, 32'd9, 32'd10, 64'd90);

    // Reset during the 3rd BUSY cycle.
    drive_accept("rst", 1'b0, 32'hFFFF, 32'hFFFF);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst out",       out,            64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready",  64'(in_ready),  64'd1);
    check("rst busy",      64'(busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 1'b0, 32'h12345678, 32'h1, 64'h12345678);

    // Request held during the handoff cycle is accepted only on the next cycle.
    drive_accept("sim", 1'b0, 32'd2, 32'd3);
    wait_result("sim", res, lat, held);
    check("sim result", res, 64'd6);
    in_valid = 1'b1; gf_option = 1'b0; a = 32'd4; b = 32'd5;
    out_ready = 1'b1;
    check("sim in_ready at handoff", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("sim idle next cycle", {62'd0, out_valid, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("sim2", res, lat, held);
    check("sim2 result", res, 64'd20);
    check("sim2 latency", 64'(lat), 64'd9);
    handoff("sim2", 64'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf_iter_mult_ctrl.md
# gf_iter_mult_ctrl

Sequential, digit-serial multiplier that computes either a carry-less GF(2)[x] product or an unsigned integer product of two DATA_WIDTH operands. It trades the area of a full-width combinational multiplier for a fixed multi-cycle latency. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. One operation is in flight at a time.

## Interface

Parameters:
- DATA_WIDTH, 32: operand width. The result is 2*DATA_WIDTH.
- DIGIT, 4: bits of b consumed per compute cycle.
  - DATA_WIDTH must be divisible by DIGIT.
  - Let N = DATA_WIDTH/DIGIT.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operand request.
- in_ready, output, 1: block can accept operands.
- gf_option, input, 1: mode select, sampled at accept. 1 = GF carry-less product, 0 = unsigned integer product.
- a, input, DATA_WIDTH: multiplicand, sampled at accept.
- b, input, DATA_WIDTH: multiplier, sampled at accept.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts result.
- out, output, 2*DATA_WIDTH: registered result.
- busy, output, 1: high in BUSY and DONE.

## Operation

- States: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = (state != IDLE).
- IDLE:
  - On in_valid && in_ready, latch the inputs: a_sh = zero-extended a (2*DATA_WIDTH), b_sh = b, mode = gf_option.
  - Clear acc, set cnt = 0, go to BUSY.
  - If in_valid is low, remain in IDLE.
- BUSY, each cycle:
  - d = b_sh[DIGIT-1:0].
  - partial = combination over j = 0..DIGIT-1 of (d[j] ? a_sh << j : 0).
  - The combining operation applies both within partial and into acc:
    - mode = 1: XOR.
    - mode = 0: 2*DATA_WIDTH-bit addition.
  - acc <= acc op partial; a_sh <<= DIGIT; b_sh >>= DIGIT; cnt <= cnt + 1.
  - When cnt == N-1: write the final acc into out and go to DONE.
- DONE:
  - out is held stable.
  - On out_ready, go to IDLE. out keeps its value until the next result is written.
- Arithmetic rules:
  - Integer mode gives the exact unsigned product; no overflow is possible in 2*DATA_WIDTH bits.
  - GF mode gives the unreduced carry-less product; bit 2*DATA_WIDTH-1 is always 0. No modular reduction is performed.
- No early termination: b == 0 still takes N compute cycles.
- in_valid asserted while in_ready is low is ignored: no sampling and no queueing. The producer must hold its request.

## Timing

- Reset values (asynchronous): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out = 0, acc = 0, cnt = 0.
- Latency:
  - Accept edge at cycle 0 → BUSY during cycles 1..N.
  - out_valid rises after the N-th BUSY edge, i.e. it is visible in cycle N+1.
  - With DATA_WIDTH = 32 and DIGIT = 4, N = 8.
- Result handshake:
  - The transfer completes on the edge where out_valid && out_ready.
  - out_valid drops and in_ready rises in the next cycle.
  - out_ready high before out_valid has no effect.
- Throughput: at most one operation per N+2 cycles (accept, N compute, handoff).
- Reset mid-operation:
  - rst_n low in any state immediately returns all outputs to reset values.
  - The partial result is discarded.
  - Operation resumes on the first clk edge after rst_n deasserts.
- Inputs a, b and gf_option may change freely after the accept edge without affecting the result.

## Test plan

All scenarios use DATA_WIDTH = 32, DIGIT = 4.

1. Integer mode, a = 0xFFFFFFFF, b = 0xFFFFFFFF → out = 0xFFFFFFFE00000001. out_valid visible exactly 9 cycles after the accept cycle.
2. a = 0x3, b = 0x3:
   - GF mode → out = 0x5.
   - Back-to-back integer mode → out = 0x9.
   - in_ready low throughout each operation.
3. GF mode, a = 0xFFFFFFFF, b = 0xFFFFFFFF → out = 0x5555555555555555.
4. Backpressure:
   - Hold out_ready = 0 for 5 cycles after out_valid rises → out stable, busy = 1, in_ready = 0.
   - A new in_valid with a = 7 during this window is ignored.
   - After out_ready pulses, the next accept computes fresh operands.
5. Reset mid-operation: assert rst_n = 0 during the 3rd BUSY cycle → out = 0, out_valid = 0 and in_ready = 1 immediately. A new integer 0x12345678 × 0x1 then yields 0x12345678.
6. Integer mode, b = 0, a = 0xDEADBEEF → out = 0, latency still 9 cycles. Then the simultaneous in_valid/out_ready boundary: the result is handed off and in_ready rises only on the following cycle.
